// File: rtl/aibnd_sig_buf_pkg.sv
// rtl/aibnd_sig_buf_pkg.sv - shared helpers for the aibnd retime buffer
package aibnd_sig_buf_pkg;

    // Width needed to encode depths 0..max_stages inclusive.
    function automatic int sel_w_of(input int max_stages);
        return (max_stages < 1) ? 1 : $clog2(max_stages + 1);
    endfunction

endpackage

// File: rtl/aibnd_sig_buf_stage.sv
// rtl/aibnd_sig_buf_stage.sv - one {vld, data} retime register with enable
module aibnd_sig_buf_stage #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             d_vld,
    input  logic [WIDTH-1:0] d_data,
    output logic             q_vld,
    output logic [WIDTH-1:0] q_data
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q_vld  <= 1'b0;
            q_data <= RST_VAL;
        end else if (en) begin
            q_vld  <= d_vld;
            q_data <= d_data;
        end
    end

endmodule

// File: rtl/aibnd_sig_pipe_buf.sv
// rtl/aibnd_sig_pipe_buf.sv - runtime-selectable depth retime buffer with flush tracking
module aibnd_sig_pipe_buf
    import aibnd_sig_buf_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter int               MAX_STAGES = 4,
    parameter logic [WIDTH-1:0] RST_VAL    = '0,
    localparam int              SEL_W      = sel_w_of(MAX_STAGES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vccl_aibnd,
    input  logic             vssl_aibnd,
    input  logic [WIDTH-1:0] sig_in,
    input  logic             sig_in_vld,
    input  logic             buf_en,
    input  logic [SEL_W-1:0] stage_sel,
    output logic [WIDTH-1:0] sig_out,
    output logic             sig_out_vld,
    output logic             busy
);

    localparam logic [SEL_W-1:0] MAX_SEL = SEL_W'(MAX_STAGES);

    typedef struct packed {
        logic             vld;
        logic [WIDTH-1:0] data;
    } stage_t;

    stage_t           stg [MAX_STAGES];
    stage_t           tap;
    logic [SEL_W-1:0] eff_sel;
    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] flush_cnt;
    logic             flush_busy;
    logic             unused_supply;

    assign unused_supply = vccl_aibnd ^ vssl_aibnd;

    genvar g;
    generate
        for (g = 0; g < MAX_STAGES; g++) begin : g_stage
            if (g == 0) begin : g_head
                aibnd_sig_buf_stage #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) u_stage (
                    .clk    (clk),
                    .rst    (rst),
                    .en     (buf_en),
                    .d_vld  (sig_in_vld),
                    .d_data (sig_in),
                    .q_vld  (stg[g].vld),
                    .q_data (stg[g].data)
                );
            end else begin : g_body
                aibnd_sig_buf_stage #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) u_stage (
                    .clk    (clk),
                    .rst    (rst),
                    .en     (buf_en),
                    .d_vld  (stg[g-1].vld),
                    .d_data (stg[g-1].data),
                    .q_vld  (stg[g].vld),
                    .q_data (stg[g].data)
                );
            end
        end
    endgenerate

    always_comb begin
        eff_sel = (stage_sel > MAX_SEL) ? MAX_SEL : stage_sel;
    end

    // The counter is loaded with the new depth so that exactly the stale contents
    // of the new tap position are masked until fresh samples reach it.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q     <= '0;
            flush_cnt <= '0;
        end else if (eff_sel != sel_q) begin
            sel_q     <= eff_sel;
            flush_cnt <= eff_sel;
        end else if (buf_en && (flush_cnt != '0)) begin
            flush_cnt <= flush_cnt - SEL_W'(1);
        end
    end

    assign flush_busy = (flush_cnt != '0);

    always_comb begin
        tap = '{vld: 1'b0, data: RST_VAL};
        for (int i = 0; i < MAX_STAGES; i++) begin
            if (sel_q == SEL_W'(i + 1)) begin
                tap = stg[i];
            end
        end
    end

    always_comb begin
        sig_out     = RST_VAL;
        sig_out_vld = 1'b0;
        busy        = 1'b0;
        if (!rst) begin
            busy = flush_busy;
            if (sel_q == '0) begin
                sig_out     = sig_in;
                sig_out_vld = sig_in_vld & buf_en;
            end else begin
                sig_out     = tap.data;
                sig_out_vld = tap.vld & buf_en & ~flush_busy;
            end
        end
    end

endmodule
